// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit.
// Issues one aligned data-memory access per load/store and holds the pipeline with stall_o
// until the memory acknowledges. Misaligned accesses are dropped and flagged for one cycle.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   wb_*_i, inst_i, pc_i upstream writeback fields (wb_data_i doubles as the access address)
//   difftest_flush_i     difftest flush tag, passed through
//   mem_*_i              load/store controls, right-aligned size mask and store data
//   dmem_*_o / dmem_*_i  registered memory request, ack and read data
//   stall_o              upstream hold request
//   misalign_o           one-cycle misaligned-access flag
//   wb_*_o, inst_o, pc_o, difftest_flush_o  registered writeback outputs
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] wb_data_i,
    input  logic [4:0]  wb_addr_i,
    input  logic        wb_en_i,
    input  logic [31:0] inst_i,
    input  logic [63:0] pc_i,
    input  logic        difftest_flush_i,
    input  logic        mem_is_signed_i,
    input  logic        mem_r_en_i,
    input  logic        mem_w_en_i,
    input  logic [7:0]  mem_mask_i,
    input  logic [63:0] mem_wr_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [7:0]  dmem_wmask_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [63:0] wb_data_o,
    output logic [4:0]  wb_addr_o,
    output logic        wb_en_o,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic        difftest_flush_o
);

    // StDone is a one-cycle marker after an ack; it behaves exactly like StIdle.
    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
    state_e state_q, state_d;

    logic        access, is_store, is_load, misaligned;
    logic [2:0]  off;
    logic [15:0] mask_shift;
    logic [63:0] rshift, load_result;
    logic        stall, misal;

    logic        req_d, we_d;
    logic [63:0] addr_d, wdata_d;
    logic [7:0]  wmask_d;
    logic [63:0] wb_data_d, pc_d;
    logic [4:0]  wb_addr_d;
    logic        wb_en_d, flush_d;
    logic [31:0] inst_d;

    assign access     = mem_r_en_i | mem_w_en_i;
    assign is_store   = mem_w_en_i;             // store wins when both are set
    assign is_load    = mem_r_en_i & ~mem_w_en_i;
    assign off        = wb_data_i[2:0];
    assign mask_shift = {8'h00, mem_mask_i} << off;
    assign misaligned = |mask_shift[15:8];      // lanes spill past the 8-byte word

    assign rshift = dmem_rdata_i >> {off, 3'b000};

    always_comb begin
        load_result = rshift;
        case (mem_mask_i)
            8'h01: load_result = mem_is_signed_i ? {{56{rshift[7]}}, rshift[7:0]}
                                                 : {56'h0, rshift[7:0]};
            8'h03: load_result = mem_is_signed_i ? {{48{rshift[15]}}, rshift[15:0]}
                                                 : {48'h0, rshift[15:0]};
            8'h0F: load_result = mem_is_signed_i ? {{32{rshift[31]}}, rshift[31:0]}
                                                 : {32'h0, rshift[31:0]};
            default: load_result = rshift;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReq:   if (dmem_ack_i) state_d = StDone;
            default: state_d = (access && !misaligned) ? StReq : StIdle;
        endcase
    end

    // Outputs and next values of the registered interfaces
    always_comb begin
        stall   = 1'b0;
        misal   = 1'b0;
        req_d   = dmem_req_o;
        we_d    = dmem_we_o;
        addr_d  = dmem_addr_o;
        wmask_d = dmem_wmask_o;
        wdata_d = dmem_wdata_o;
        case (state_q)
            StReq: begin
                stall = ~dmem_ack_i;
                if (dmem_ack_i) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 64'h0;
                    wmask_d = 8'h00;
                    wdata_d = 64'h0;
                end
            end
            default: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = 64'h0;
                wmask_d = 8'h00;
                wdata_d = 64'h0;
                if (access && misaligned) begin
                    misal = 1'b1;
                end else if (access) begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {wb_data_i[63:3], 3'b000};
                    wmask_d = is_store ? mask_shift[7:0] : 8'h00;
                    wdata_d = mem_wr_data_i << {off, 3'b000};
                end
            end
        endcase

        if (stall) begin
            wb_data_d = 64'h0;
            wb_addr_d = 5'h0;
            wb_en_d   = 1'b0;
            inst_d    = 32'h0;
            pc_d      = 64'h0;
            flush_d   = 1'b0;
        end else begin
            // Only a completing load replaces the ALU result.
            wb_data_d = (is_load && state_q == StReq) ? load_result : wb_data_i;
            wb_addr_d = wb_addr_i;
            wb_en_d   = wb_en_i & ~misal;
            inst_d    = inst_i;
            pc_d      = pc_i;
            flush_d   = difftest_flush_i;
        end
    end

    // Combinational flags are forced low while reset is held.
    assign stall_o    = rst & stall;
    assign misalign_o = rst & misal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req_o       <= 1'b0;
            dmem_we_o        <= 1'b0;
            dmem_addr_o      <= 64'h0;
            dmem_wmask_o     <= 8'h00;
            dmem_wdata_o     <= 64'h0;
            wb_data_o        <= 64'h0;
            wb_addr_o        <= 5'h0;
            wb_en_o          <= 1'b0;
            inst_o           <= 32'h0;
            pc_o             <= 64'h0;
            difftest_flush_o <= 1'b0;
        end else begin
            dmem_req_o       <= req_d;
            dmem_we_o        <= we_d;
            dmem_addr_o      <= addr_d;
            dmem_wmask_o     <= wmask_d;
            dmem_wdata_o     <= wdata_d;
            wb_data_o        <= wb_data_d;
            wb_addr_o        <= wb_addr_d;
            wb_en_o          <= wb_en_d;
            inst_o           <= inst_d;
            pc_o             <= pc_d;
            difftest_flush_o <= flush_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk, rst;
    logic [63:0] wb_data_i, pc_i, mem_wr_data_i, dmem_rdata_i;
    logic [4:0]  wb_addr_i;
    logic        wb_en_i, difftest_flush_i, mem_is_signed_i, mem_r_en_i, mem_w_en_i;
    logic [31:0] inst_i;
    logic [7:0]  mem_mask_i;
    logic        dmem_ack_i;
    logic        dmem_req_o, dmem_we_o, stall_o, misalign_o, wb_en_o, difftest_flush_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o, wb_data_o, pc_o;
    logic [7:0]  dmem_wmask_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] inst_o;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_en_i(wb_en_i),
        .inst_i(inst_i), .pc_i(pc_i), .difftest_flush_i(difftest_flush_i),
        .mem_is_signed_i(mem_is_signed_i), .mem_r_en_i(mem_r_en_i), .mem_w_en_i(mem_w_en_i),
        .mem_mask_i(mem_mask_i), .mem_wr_data_i(mem_wr_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wmask_o(dmem_wmask_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .misalign_o(misalign_o),
        .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o), .wb_en_o(wb_en_o),
        .inst_o(inst_o), .pc_o(pc_o), .difftest_flush_o(difftest_flush_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic f_mis(input logic [7:0] mask, input logic [2:0] off);
        return ($countones(mask) + int'(off)) > 8;
    endfunction

    function automatic logic [7:0] f_lanes(input logic [7:0] mask, input logic [2:0] off);
        logic [15:0] l;
        l = ((16'h1 << $countones(mask)) - 16'h1) << off;
        return l[7:0];
    endfunction

    function automatic logic [63:0] f_load(input logic [63:0] rd, input logic [2:0] off,
                                           input logic [7:0] mask, input logic sgn);
        int nb;
        logic [127:0] v, lm;
        nb = $countones(mask);
        v  = {64'h0, rd >> (8 * int'(off))};
        lm = (128'h1 << (8 * nb)) - 128'h1;
        v  = v & lm;
        if (sgn && v[8 * nb - 1]) v = v | ~lm;
        return v[63:0];
    endfunction

    logic        acc, mis, ld;
    logic        m_busy, m_req, m_we, m_wb_en, m_flush;
    logic [63:0] m_addr, m_wdata, m_wb_data, m_pc;
    logic [7:0]  m_wmask;
    logic [4:0]  m_wb_addr;
    logic [31:0] m_inst;
    logic        exp_stall, exp_mis;

    assign acc       = mem_r_en_i | mem_w_en_i;
    assign ld        = mem_r_en_i & ~mem_w_en_i;
    assign mis       = f_mis(mem_mask_i, wb_data_i[2:0]);
    assign exp_stall = rst && (m_busy ? !dmem_ack_i : (acc && !mis));
    assign exp_mis   = rst && !m_busy && acc && mis;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_req <= 0; m_we <= 0; m_addr <= 0; m_wmask <= 0; m_wdata <= 0;
            m_wb_data <= 0; m_wb_addr <= 0; m_wb_en <= 0; m_inst <= 0; m_pc <= 0;
            m_flush <= 0;
        end else begin
            if (exp_stall) begin
                m_wb_data <= 0; m_wb_addr <= 0; m_wb_en <= 0; m_inst <= 0; m_pc <= 0;
                m_flush <= 0;
            end else begin
                m_wb_data <= (m_busy && ld)
                    ? f_load(dmem_rdata_i, wb_data_i[2:0], mem_mask_i, mem_is_signed_i)
                    : wb_data_i;
                m_wb_en   <= wb_en_i && !exp_mis;
                m_wb_addr <= wb_addr_i;
                m_inst    <= inst_i;
                m_pc      <= pc_i;
                m_flush   <= difftest_flush_i;
            end
            if (m_busy) begin
                if (dmem_ack_i) begin
                    m_busy <= 0; m_req <= 0; m_we <= 0; m_addr <= 0; m_wmask <= 0;
                    m_wdata <= 0;
                end
            end else if (acc && !mis) begin
                m_busy  <= 1;
                m_req   <= 1;
                m_we    <= mem_w_en_i;
                m_addr  <= wb_data_i & ~64'h7;
                m_wmask <= mem_w_en_i ? f_lanes(mem_mask_i, wb_data_i[2:0]) : 8'h00;
                m_wdata <= mem_wr_data_i << (8 * int'(wb_data_i[2:0]));
            end else begin
                m_req <= 0; m_we <= 0; m_addr <= 0; m_wmask <= 0; m_wdata <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("stall_o", 64'(stall_o), 64'(exp_stall));
        chk("misalign_o", 64'(misalign_o), 64'(exp_mis));
        chk("dmem_req_o", 64'(dmem_req_o), 64'(m_req));
        chk("dmem_we_o", 64'(dmem_we_o), 64'(m_we));
        chk("dmem_addr_o", dmem_addr_o, m_addr);
        chk("dmem_wmask_o", 64'(dmem_wmask_o), 64'(m_wmask));
        chk("dmem_wdata_o", dmem_wdata_o, m_wdata);
        chk("wb_data_o", wb_data_o, m_wb_data);
        chk("wb_addr_o", 64'(wb_addr_o), 64'(m_wb_addr));
        chk("wb_en_o", 64'(wb_en_o), 64'(m_wb_en));
        chk("inst_o", 64'(inst_o), 64'(m_inst));
        chk("pc_o", pc_o, m_pc);
        chk("difftest_flush_o", 64'(difftest_flush_o), 64'(m_flush));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb_data_i = 0; wb_addr_i = 0; wb_en_i = 0; inst_i = 0; pc_i = 0;
        difftest_flush_i = 0; mem_is_signed_i = 0; mem_r_en_i = 0; mem_w_en_i = 0;
        mem_mask_i = 0; mem_wr_data_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    endtask

    task automatic set_op(input logic [63:0] a, input logic r, input logic w,
                          input logic [7:0] m, input logic s, input logic [63:0] wd,
                          input logic en, input logic [4:0] rd);
        wb_data_i = a; mem_r_en_i = r; mem_w_en_i = w; mem_mask_i = m;
        mem_is_signed_i = s; mem_wr_data_i = wd; wb_en_i = en; wb_addr_i = rd;
        inst_i = 32'h0000_0013; pc_i = 64'h8000_0000 + a; difftest_flush_i = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        idle_in();
        mem_r_en_i = 1'b1;                 // access visible during reset must not stall
        #12;
        chk("reset stall_o", 64'(stall_o), 64'h0);
        chk("reset dmem_req_o", 64'(dmem_req_o), 64'h0);
        chk("reset wb_en_o", 64'(wb_en_o), 64'h0);
        step();
        idle_in();
        rst = 1'b1;

        // Non-memory passthrough
        step();
        set_op(64'h1234, 0, 0, 8'h00, 0, 0, 1, 5'd5);
        #1 chk("pass stall_o", 64'(stall_o), 64'h0);
        step();
        idle_in();
        chk("pass wb_data_o", wb_data_o, 64'h1234);
        chk("pass wb_en_o", 64'(wb_en_o), 64'h1);
        chk("pass wb_addr_o", 64'(wb_addr_o), 64'h5);

        // Signed byte load, ack in first REQ cycle
        step();
        set_op(64'h1003, 1, 0, 8'h01, 1, 0, 1, 5'd7);
        #1 chk("lb stall_o", 64'(stall_o), 64'h1);
        step();
        chk("lb dmem_req_o", 64'(dmem_req_o), 64'h1);
        chk("lb dmem_addr_o", dmem_addr_o, 64'h1000);
        chk("lb dmem_we_o", 64'(dmem_we_o), 64'h0);
        dmem_ack_i = 1; dmem_rdata_i = 64'h0000_0000_8000_0000;
        #1 chk("lb ack stall_o", 64'(stall_o), 64'h0);
        step();
        idle_in();
        chk("lb wb_data_o", wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb wb_en_o", 64'(wb_en_o), 64'h1);
        chk("lb req dropped", 64'(dmem_req_o), 64'h0);

        // Word store
        step();
        set_op(64'h2004, 0, 1, 8'h0F, 0, 64'hDEAD_BEEF, 0, 5'd0);
        step();
        chk("sw dmem_we_o", 64'(dmem_we_o), 64'h1);
        chk("sw dmem_wmask_o", 64'(dmem_wmask_o), 64'hF0);
        chk("sw dmem_wdata_o", dmem_wdata_o, 64'hDEAD_BEEF_0000_0000);
        dmem_ack_i = 1;
        step();
        idle_in();
        chk("sw req dropped", 64'(dmem_req_o), 64'h0);

        // Unsigned halfword load, ack three cycles late
        step();
        set_op(64'h4006, 1, 0, 8'h03, 0, 0, 1, 5'd9);
        n = 0;
        #1 if (stall_o) n++;
        for (int k = 0; k < 3; k++) begin
            step();
            #1 if (stall_o) n++;
            chk("lh late dmem_addr_o", dmem_addr_o, 64'h4000);
            chk("lh late bubble wb_en_o", 64'(wb_en_o), 64'h0);
        end
        step();
        dmem_ack_i = 1; dmem_rdata_i = 64'hABCD_0000_0000_0000;
        #1 if (stall_o) n++;
        chk("lh stall cycles", 64'(n), 64'd4);
        // Back-to-back: signed word load right after the return
        step();
        dmem_ack_i = 0;
        set_op(64'h5004, 1, 0, 8'h0F, 1, 0, 1, 5'd10);
        #1 chk("lh wb_data_o", wb_data_o, 64'h0000_0000_0000_ABCD);
        chk("b2b stall_o", 64'(stall_o), 64'h1);
        step();
        chk("b2b dmem_req_o", 64'(dmem_req_o), 64'h1);
        chk("b2b dmem_addr_o", dmem_addr_o, 64'h5000);
        dmem_ack_i = 1; dmem_rdata_i = 64'h8000_0001_0000_0000;
        step();
        idle_in();
        chk("lw wb_data_o", wb_data_o, 64'hFFFF_FFFF_8000_0001);

        // Misaligned doubleword
        step();
        set_op(64'h3001, 1, 0, 8'hFF, 0, 0, 1, 5'd3);
        #1 chk("mis misalign_o", 64'(misalign_o), 64'h1);
        chk("mis stall_o", 64'(stall_o), 64'h0);
        step();
        idle_in();
        #1 chk("mis misalign_o after", 64'(misalign_o), 64'h0);
        chk("mis dmem_req_o", 64'(dmem_req_o), 64'h0);
        chk("mis wb_en_o", 64'(wb_en_o), 64'h0);

        // Load and store both requested: store only
        step();
        set_op(64'h6002, 1, 1, 8'h03, 0, 64'h1122, 1, 5'd4);
        step();
        chk("rw dmem_we_o", 64'(dmem_we_o), 64'h1);
        chk("rw dmem_wmask_o", 64'(dmem_wmask_o), 64'h0C);
        chk("rw dmem_wdata_o", dmem_wdata_o, 64'h1122_0000);
        dmem_ack_i = 1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        idle_in();
        chk("rw wb_data_o", wb_data_o, 64'h6002);

        // Reset in the middle of an access
        step();
        set_op(64'h7000, 1, 0, 8'hFF, 0, 0, 1, 5'd2);
        step();
        chk("rst pre dmem_req_o", 64'(dmem_req_o), 64'h1);
        rst = 1'b0;
        dmem_ack_i = 1;
        #1 chk("rst async dmem_req_o", 64'(dmem_req_o), 64'h0);
        chk("rst stall_o", 64'(stall_o), 64'h0);
        step();
        chk("rst wb_en_o", 64'(wb_en_o), 64'h0);
        idle_in();
        dmem_ack_i = 1;                    // stray ack while idle
        rst = 1'b1;
        step();
        dmem_ack_i = 0;
        chk("post rst dmem_req_o", 64'(dmem_req_o), 64'h0);
        chk("post rst wb_data_o", wb_data_o, 64'h0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
